// File: rtl/round_key_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : round_key_arbiter
//  Description : Owns the single-port 44 x 32-bit round-key store. The key
//                generator writes words and is never stalled. The cipher
//                round engine reads a 128-bit round key once all four of its
//                words have been written, using store cycles left free.
//  Revision    : 1.0 - initial release
// ============================================================================
module round_key_arbiter #(
    parameter int NROUNDS = 11,
    parameter int IDX_W   = 4,
    parameter int BLK_W   = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    // key generator (writer)
    input  logic                      kg_start,
    input  logic                      kg_wr_en,
    input  logic [IDX_W-1:0]          kg_index,
    input  logic [BLK_W-1:0]          kg_blk,
    input  logic [31:0]               kg_wdata,
    // cipher round engine (reader)
    input  logic                      ci_req,
    input  logic [IDX_W-1:0]          ci_index,
    output logic                      ci_ack,
    output logic                      ci_err,
    output logic [(32<<BLK_W)-1:0]    ci_rkey,
    // key schedule status
    output logic [NROUNDS-1:0]        ks_valid,
    output logic                      key_ready,
    // round-key store port
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [IDX_W+BLK_W-1:0]    mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic [31:0]               mem_rdata
);

    localparam int               c_WORDS = 1 << BLK_W;
    localparam logic [IDX_W-1:0] c_NR    = IDX_W'(NROUNDS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_READ = 3'd2,
        S_LAST = 3'd3,
        S_ACK  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t                           r_state;
    logic [NROUNDS-1:0][c_WORDS-1:0]  r_mask;
    logic [NROUNDS-1:0][c_WORDS-1:0]  w_mask_nxt;
    logic [NROUNDS-1:0]               w_valid_nxt;
    logic                             w_req_valid_nxt;
    logic                             w_issue;
    logic [BLK_W-1:0]                 r_cnt;
    logic                             r_rd_pend;
    logic [BLK_W-1:0]                 r_wptr;
    logic [c_WORDS-1:0][31:0]         r_rkey;
    logic                             r_ci_ack;
    logic                             r_ci_err;

    // Mask update for this cycle: a new key load clears first, then the
    // word written in the same cycle (if in range) is marked present.
    always_comb begin
        w_mask_nxt = r_mask;
        if (kg_start) begin
            w_mask_nxt = '0;
        end
        if (kg_wr_en && (kg_index < c_NR)) begin
            w_mask_nxt[kg_index][kg_blk] = 1'b1;
        end
    end

    generate
        for (genvar g = 0; g < NROUNDS; g++) begin : g_valid
            assign ks_valid[g]    = &r_mask[g];
            assign w_valid_nxt[g] = &w_mask_nxt[g];
        end
    endgenerate

    // The FSM looks at next-cycle validity so a round completed by this
    // cycle's write (and invalidated by this cycle's kg_start) is honoured
    // without an extra cycle of delay.
    assign w_req_valid_nxt = (ci_index < c_NR) ? w_valid_nxt[ci_index] : 1'b0;

    // Reader only issues in cycles the writer leaves free; an abort cycle
    // never issues.
    assign w_issue   = (r_state == S_READ) && !kg_wr_en && !kg_start;

    assign key_ready = &ks_valid;
    assign mem_en    = kg_wr_en | w_issue;
    assign mem_we    = kg_wr_en;
    assign mem_addr  = kg_wr_en ? {kg_index, kg_blk} : {ci_index, r_cnt};
    assign mem_wdata = kg_wdata;
    assign ci_ack    = r_ci_ack;
    assign ci_err    = r_ci_err;
    assign ci_rkey   = r_rkey;

    // Per-round word-present masks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
        end else begin
            r_mask <= w_mask_nxt;
        end
    end

    // Request FSM, read-data capture and registered handshake pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rd_pend <= 1'b0;
            r_wptr    <= '0;
            r_rkey    <= '0;
            r_ci_ack  <= 1'b0;
            r_ci_err  <= 1'b0;
        end else begin
            r_ci_ack  <= 1'b0;
            r_ci_err  <= 1'b0;
            r_rd_pend <= w_issue;
            r_wptr    <= r_cnt;
            // Word 0 sits in the top slice, so slot index is the inverted pointer.
            if (r_rd_pend) begin
                r_rkey[~r_wptr] <= mem_rdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (ci_req) begin
                        r_cnt <= '0;
                        if (ci_index >= c_NR) begin
                            r_state  <= S_ERR;
                            r_ci_err <= 1'b1;
                        end else if (w_req_valid_nxt) begin
                            r_state <= S_READ;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= '0;
                    if (w_req_valid_nxt) begin
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (kg_start) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                    end else if (w_issue) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (&r_cnt) begin
                            r_state <= S_LAST;
                        end
                    end
                end
                S_LAST: begin
                    if (kg_start) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                    end else begin
                        r_state  <= S_ACK;
                        r_ci_ack <= 1'b1;
                    end
                end
                S_ACK:   r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_round_key_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_round_key_arbiter
//  Description : Self-checking bench for round_key_arbiter with a store model,
//                a transaction-level reference model and directed + random
//                stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_round_key_arbiter;

    localparam int NR = 11;

    logic         clk;
    logic         reset_n;
    logic         kg_start;
    logic         kg_wr_en;
    logic [3:0]   kg_index;
    logic [1:0]   kg_blk;
    logic [31:0]  kg_wdata;
    logic         ci_req;
    logic [3:0]   ci_index;
    logic         ci_ack;
    logic         ci_err;
    logic [127:0] ci_rkey;
    logic [10:0]  ks_valid;
    logic         key_ready;
    logic         mem_en;
    logic         mem_we;
    logic [5:0]   mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;

    round_key_arbiter #(.NROUNDS(11), .IDX_W(4), .BLK_W(2)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .kg_start  (kg_start),
        .kg_wr_en  (kg_wr_en),
        .kg_index  (kg_index),
        .kg_blk    (kg_blk),
        .kg_wdata  (kg_wdata),
        .ci_req    (ci_req),
        .ci_index  (ci_index),
        .ci_ack    (ci_ack),
        .ci_err    (ci_err),
        .ci_rkey   (ci_rkey),
        .ks_valid  (ks_valid),
        .key_ready (key_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port store: one-cycle read latency.
    logic [31:0] env_store [64];
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we) env_store[mem_addr] <= mem_wdata;
            else        mem_rdata <= env_store[mem_addr];
        end
    end

    // Reference model: what the store holds, which words of each round exist,
    // and where the outstanding cipher request stands.
    logic [31:0] m_store [64];
    bit   [3:0]  m_mask  [NR];
    bit          m_pend, m_fetch, m_ack, m_err;
    int          m_issued;
    logic [3:0]  m_idx;
    logic [31:0] m_key [4];
    logic [127:0] m_rkey;

    int n_cmp, n_fail, cyc;
    bit last_ack, last_err, last_en, last_we;
    int last_cyc;
    logic [5:0] last_addr;
    logic [5:0] reads [$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int i, input int b, input logic [7:0] salt);
        logic [3:0] i4;
        logic [1:0] b2;
        i4 = 4'(i);
        b2 = 2'(b);
        return {i4, b2, 2'b00, salt, 10'h2A5, i4, b2};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) m_mask[r] = 4'h0;
        m_pend = 0; m_fetch = 0; m_ack = 0; m_err = 0; m_issued = 0;
    endtask

    task automatic model_advance(input bit issue);
        bit [3:0] nm [NR];
        bit was_ack, was_err;
        for (int r = 0; r < NR; r++) nm[r] = kg_start ? 4'h0 : m_mask[r];
        if (kg_wr_en && kg_index < NR) nm[kg_index][kg_blk] = 1'b1;
        if (issue) m_key[m_issued] = m_store[{m_idx, 2'(m_issued)}];
        if (kg_wr_en) m_store[{kg_index, kg_blk}] = kg_wdata;
        was_ack = m_ack; was_err = m_err;
        m_ack = 0; m_err = 0;
        if (!m_pend && !was_ack && !was_err) begin
            if (ci_req) begin
                if (ci_index >= NR) m_err = 1;
                else begin
                    m_pend = 1; m_idx = ci_index; m_issued = 0;
                    m_fetch = &nm[ci_index];
                end
            end
        end else if (m_pend) begin
            if (kg_start) begin
                m_fetch = 0; m_issued = 0;
            end else if (!m_fetch) begin
                m_fetch = &nm[m_idx];
            end else if (issue) begin
                m_issued++;
            end else if (m_issued == 4) begin
                m_pend = 0; m_fetch = 0; m_ack = 1;
                m_rkey = {m_key[0], m_key[1], m_key[2], m_key[3]};
            end
        end
        for (int r = 0; r < NR; r++) m_mask[r] = nm[r];
    endtask

    // One clock cycle: compare every output at the falling edge, then advance.
    task automatic step();
        bit issue;
        logic [10:0] ev;
        logic [5:0] eaddr;
        @(negedge clk);
        issue = m_fetch && (m_issued < 4) && !kg_wr_en && !kg_start;
        for (int r = 0; r < NR; r++) ev[r] = &m_mask[r];
        chk("ci_ack", 128'(ci_ack), 128'(m_ack));
        chk("ci_err", 128'(ci_err), 128'(m_err));
        chk("ks_valid", 128'(ks_valid), 128'(ev));
        chk("key_ready", 128'(key_ready), 128'(&ev));
        chk("mem_en", 128'(mem_en), 128'(kg_wr_en | issue));
        if (kg_wr_en || issue) begin
            eaddr = kg_wr_en ? {kg_index, kg_blk} : {m_idx, 2'(m_issued)};
            chk("mem_we", 128'(mem_we), 128'(kg_wr_en));
            chk("mem_addr", 128'(mem_addr), 128'(eaddr));
        end
        if (kg_wr_en) chk("mem_wdata", 128'(mem_wdata), 128'(kg_wdata));
        if (m_ack) chk("ci_rkey", ci_rkey, m_rkey);
        last_ack = ci_ack; last_err = ci_err; last_cyc = cyc;
        last_en = mem_en; last_we = mem_we; last_addr = mem_addr;
        if (mem_en && !mem_we) reads.push_back(mem_addr);
        model_advance(issue);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic write_word(input int i, input int b, input logic [7:0] s);
        kg_wr_en = 1'b1; kg_index = 4'(i); kg_blk = 2'(b); kg_wdata = word_of(i, b, s);
        step();
        kg_wr_en = 1'b0;
    endtask

    task automatic write_round(input int i, input logic [7:0] s);
        for (int b = 0; b < 4; b++) write_word(i, b, s);
    endtask

    task automatic run_until_done(input int bound, output int at_cyc, output bit was_ack);
        bit done;
        done = 0; at_cyc = -1; was_ack = 0;
        for (int k = 0; k < bound && !done; k++) begin
            step();
            if (last_ack || last_err) begin
                done = 1; at_cyc = last_cyc; was_ack = last_ack; ci_req = 1'b0;
            end
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_done: no ack/err within %0d cycles", bound);
            ci_req = 1'b0;
        end
    endtask

    task automatic do_reset();
        kg_start = 0; kg_wr_en = 0; ci_req = 0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_ack", 128'(ci_ack), 128'(0));
        chk("rst_err", 128'(ci_err), 128'(0));
        chk("rst_rkey", ci_rkey, 128'(0));
        chk("rst_ks_valid", 128'(ks_valid), 128'(0));
        chk("rst_key_ready", 128'(key_ready), 128'(0));
        chk("rst_mem_en", 128'(mem_en), 128'(0));
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    function automatic logic [127:0] round_of(input int i, input logic [7:0] s);
        return {word_of(i, 0, s), word_of(i, 1, s), word_of(i, 2, s), word_of(i, 3, s)};
    endfunction

    initial begin
        int  t0, tack, n_ack;
        bit  wa, busy;
        n_cmp = 0; n_fail = 0; cyc = 0;
        reset_n = 1'b1; kg_start = 0; kg_wr_en = 0; kg_index = 0; kg_blk = 0;
        kg_wdata = 0; ci_req = 0; ci_index = 0;
        for (int a = 0; a < 64; a++) begin env_store[a] = 32'h0; m_store[a] = 32'h0; end
        m_idx = 0; m_rkey = '0;
        for (int k = 0; k < 4; k++) m_key[k] = 32'h0;
        model_reset();
        do_reset();

        // 1: fill every round, then fetch round 5
        for (int i = 0; i < NR; i++) write_round(i, 8'h11);
        chk("t1_key_ready", 128'(key_ready), 128'(1));
        ci_req = 1; ci_index = 4'd5; t0 = cyc;
        run_until_done(20, tack, wa);
        chk("t1_latency", 128'(tack - t0), 128'(6));
        chk("t1_is_ack", 128'(wa), 128'(1));
        chk("t1_rkey", ci_rkey, round_of(5, 8'h11));

        // 2: request before the round exists; read starts right after last write
        do_reset();
        reads.delete();
        ci_req = 1; ci_index = 4'd3;
        repeat (5) step();
        chk("t2_no_reads", 128'(reads.size()), 128'(0));
        write_round(3, 8'h22);
        step();
        chk("t2_first_read", 128'({last_en, last_we, last_addr}), 128'({1'b1, 1'b0, 6'd12}));
        run_until_done(20, tack, wa);
        chk("t2_rkey", ci_rkey, round_of(3, 8'h22));

        // 3: writes collide with issue cycles 2 and 3
        write_round(7, 8'h77);
        reads.delete();
        ci_req = 1; ci_index = 4'd7; t0 = cyc;
        step(); step();
        kg_wr_en = 1; kg_index = 4'd9; kg_blk = 2'd0; kg_wdata = 32'hCAFE0001;
        step();
        kg_blk = 2'd1; kg_wdata = 32'hCAFE0002;
        step();
        kg_wr_en = 0;
        run_until_done(20, tack, wa);
        chk("t3_latency", 128'(tack - t0), 128'(8));
        chk("t3_nreads", 128'(reads.size()), 128'(4));
        for (int k = 0; k < 4 && k < reads.size(); k++)
            chk("t3_read_addr", 128'(reads[k]), 128'(28 + k));
        chk("t3_rkey", ci_rkey, round_of(7, 8'h77));

        // 4: out-of-range indices
        for (int k = 0; k < 2; k++) begin
            reads.delete();
            ci_req = 1; ci_index = (k == 0) ? 4'd11 : 4'd15; t0 = cyc;
            run_until_done(5, tack, wa);
            chk("t4_err_latency", 128'(tack - t0), 128'(1));
            chk("t4_not_ack", 128'(wa), 128'(0));
            chk("t4_no_reads", 128'(reads.size()), 128'(0));
        end

        // 5: new key load aborts an in-flight read
        write_round(2, 8'h33);
        ci_req = 1; ci_index = 4'd2;
        step(); step();
        kg_start = 1;
        step();
        kg_start = 0;
        chk("t5_ks_valid_clear", 128'(ks_valid), 128'(0));
        write_round(2, 8'h44);
        run_until_done(20, tack, wa);
        chk("t5_is_ack", 128'(wa), 128'(1));
        chk("t5_rkey", ci_rkey, round_of(2, 8'h44));

        // 6: asynchronous reset in the middle of a read
        write_round(4, 8'h55);
        ci_req = 1; ci_index = 4'd4;
        step(); step(); step();
        do_reset();
        n_ack = 0;
        repeat (10) begin step(); if (last_ack) n_ack++; end
        chk("t6_no_ack", 128'(n_ack), 128'(0));

        // Random traffic against the model
        busy = 0;
        for (int n = 0; n < 3000; n++) begin
            kg_start = ($urandom_range(0, 79) == 0);
            kg_wr_en = 1'($urandom_range(0, 1));
            kg_index = (busy && $urandom_range(0, 1) == 1) ? ci_index : 4'($urandom_range(0, 12));
            kg_blk   = 2'($urandom_range(0, 3));
            kg_wdata = $urandom;
            if (!busy && $urandom_range(0, 2) == 0) begin
                ci_req = 1; ci_index = 4'($urandom_range(0, 12)); busy = 1;
            end
            step();
            if (last_ack || last_err) begin ci_req = 0; busy = 0; end
        end
        kg_start = 0; kg_wr_en = 0; ci_req = 0;
        repeat (8) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
